// File: rtl/blockade_audio_pkg.sv
// Shared audio-path constants, FSM/MAC encodings and the 16-bit saturator
// used by the time-multiplexed IIR sequencer.
package blockade_audio_pkg;

    localparam int CW    = 18;
    localparam int SHIFT = 15;
    localparam int ACCW  = 36;

    // 723.43 Hz first-order low-pass
    localparam int A2_DEF = -32312;
    localparam int B1_DEF = 228;
    localparam int B2_DEF = 228;

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, STORE, DONE} state_t;
    typedef enum logic [1:0] {MAC_HOLD, MAC_LOAD, MAC_ADD, MAC_SUB} mac_op_t;

    localparam logic signed [ACCW-1:0] SAT_MAX = 36'sd32767;
    localparam logic signed [ACCW-1:0] SAT_MIN = -36'sd32768;

    function automatic logic signed [15:0] sat16(input logic signed [ACCW-1:0] v);
        if (v > SAT_MAX)
            return 16'sh7fff;
        else if (v < SAT_MIN)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/blockade_iir_mac.sv
// Shared multiply-accumulate for the IIR sequencer: operand mux, 18x16 signed
// multiply, 36-bit accumulator and the saturating output stage.
module blockade_iir_mac #(
    parameter int CW    = blockade_audio_pkg::CW,
    parameter int SHIFT = blockade_audio_pkg::SHIFT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  blockade_audio_pkg::mac_op_t op,
    input  logic signed [CW-1:0]        a2,
    input  logic signed [CW-1:0]        b1,
    input  logic signed [CW-1:0]        b2,
    input  logic signed [15:0]          x,
    input  logic signed [15:0]          xp,
    input  logic signed [15:0]          yp,
    output logic signed [15:0]          yn
);
    import blockade_audio_pkg::*;

    localparam int PW = CW + 16;

    logic signed [CW-1:0]   coef;
    logic signed [15:0]     samp;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prodx;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] shd;

    always_comb begin
        coef = '0;
        samp = '0;
        case (op)
            MAC_LOAD: begin coef = b1; samp = x;  end
            MAC_ADD:  begin coef = b2; samp = xp; end
            MAC_SUB:  begin coef = a2; samp = yp; end
            default:  ;
        endcase
    end

    assign prod  = coef * samp;
    assign prodx = {{(ACCW-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else begin
            case (op)
                MAC_LOAD: acc <= prodx;
                MAC_ADD:  acc <= acc + prodx;
                MAC_SUB:  acc <= acc - prodx;
                default:  acc <= acc;
            endcase
        end
    end

    // arithmetic shift floors toward -inf before clamping
    assign shd = acc >>> SHIFT;
    assign yn  = sat16(shd);

endmodule

// File: rtl/blockade_iir_sched.sv
// First-order IIR low-pass sequencer: one MAC shared across NCH channels,
// one frame per divider tick, all outputs published together.
module blockade_iir_sched #(
    parameter int NCH   = 2,
    parameter int CW    = blockade_audio_pkg::CW,
    parameter int SHIFT = blockade_audio_pkg::SHIFT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          div,
    input  logic [CW-1:0]       A2,
    input  logic [CW-1:0]       B1,
    input  logic [CW-1:0]       B2,
    input  logic [NCH*16-1:0]   in,
    output logic [NCH*16-1:0]   out,
    output logic                out_valid,
    output logic                busy,
    output logic                overrun
);
    import blockade_audio_pkg::*;

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [9:0]            cnt, div_q, div_eff;
    logic                  tick;
    state_t                state, nstate;
    mac_op_t               op;
    logic [CHW-1:0]        ch;
    logic                  last_ch;
    logic signed [CW-1:0]  a2f, b1f, b2f;
    logic signed [15:0]    xf [NCH];
    logic signed [15:0]    xp [NCH];
    logic signed [15:0]    yp [NCH];
    logic signed [15:0]    sh [NCH];
    logic signed [15:0]    yn;

    // new period is only picked up at the wrap so a frame period is never cut short
    assign div_eff = (div == '0) ? 10'd1 : div;
    assign tick    = (cnt == div_q - 10'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            div_q <= div_eff;
        end else if (tick) begin
            cnt   <= '0;
            div_q <= div_eff;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

    assign last_ch = (ch == CHW'(NCH - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        op     = MAC_HOLD;
        case (state)
            IDLE:  if (tick) nstate = MAC0;
            MAC0:  begin op = MAC_LOAD; nstate = MAC1; end
            MAC1:  begin op = MAC_ADD;  nstate = MAC2; end
            MAC2:  begin op = MAC_SUB;  nstate = STORE; end
            STORE: nstate = last_ch ? DONE : MAC0;
            DONE:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    assign busy      = (state == MAC0) || (state == MAC1) || (state == MAC2) ||
                       (state == STORE) || ((state == IDLE) && tick);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
            ch      <= '0;
            a2f     <= '0;
            b1f     <= '0;
            b2f     <= '0;
            out     <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                xf[k] <= '0;
                xp[k] <= '0;
                yp[k] <= '0;
                sh[k] <= '0;
            end
        end else begin
            if (tick && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                IDLE: if (tick) begin
                    a2f <= A2;
                    b1f <= B1;
                    b2f <= B2;
                    ch  <= '0;
                    for (int unsigned k = 0; k < NCH; k++)
                        xf[k] <= in[16*k +: 16];
                end
                STORE: begin
                    yp[ch] <= yn;
                    xp[ch] <= xf[ch];
                    sh[ch] <= yn;
                    // last channel bypasses the shadow so every channel lands in out at once
                    if (last_ch) begin
                        for (int unsigned k = 0; k < NCH; k++)
                            out[16*k +: 16] <= (CHW'(k) == ch) ? yn : sh[k];
                    end else begin
                        ch <= ch + CHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    blockade_iir_mac #(
        .CW    (CW),
        .SHIFT (SHIFT)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .a2    (a2f),
        .b1    (b1f),
        .b2    (b2f),
        .x     (xf[ch]),
        .xp    (xp[ch]),
        .yp    (yp[ch]),
        .yn    (yn)
    );

endmodule

// File: tb/tb_blockade_iir_sched.sv
// Directed bench for blockade_iir_sched: hand-computed frame table plus
// latency, saturation, overrun, mid-frame reset and coefficient-change sequences.
module tb_blockade_iir_sched;
    import blockade_audio_pkg::*;

    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  div;
    logic [17:0] A2, B1, B2;
    logic [31:0] in, out;
    logic        out_valid, busy, overrun;

    int a2v, b1v, b2v;
    int xv [NCH];
    int xp_m [NCH], yp_m [NCH], exp_y [NCH];
    int errors = 0;
    int checks = 0;

    assign A2 = a2v[17:0];
    assign B1 = b1v[17:0];
    assign B2 = b2v[17:0];
    assign in = {xv[1][15:0], xv[0][15:0]};

    blockade_iir_sched #(.NCH(NCH), .CW(18), .SHIFT(15)) dut (
        .clk(clk), .reset(reset), .div(div), .A2(A2), .B1(B1), .B2(B2),
        .in(in), .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int b1, b2, a2, x0, x1, e0, e1;
    } vec_t;

    function automatic int outch(int k);
        return int'($signed(out[16*k +: 16]));
    endfunction

    task automatic check(string name, int got, int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic wait_start();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL frame_start: timeout waiting for busy");
        end
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL out_valid: timeout waiting for out_valid");
        end
    endtask

    function automatic int sat(longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            xp_m[k] = 0; yp_m[k] = 0;
        end
    endtask

    task automatic model_latch();
        longint acc;
        for (int k = 0; k < NCH; k++) begin
            acc = longint'(b1v) * xv[k] + longint'(b2v) * xp_m[k] - longint'(a2v) * yp_m[k];
            exp_y[k] = sat(acc >>> 15);
            yp_m[k]  = exp_y[k];
            xp_m[k]  = xv[k];
        end
    endtask

    task automatic do_frame(string name);
        wait_start();
        model_latch();
        wait_valid();
        check({name, "_ch0"}, outch(0), exp_y[0]);
        check({name, "_ch1"}, outch(1), exp_y[1]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    vec_t tbl [6];
    int prev;

    initial begin
        tbl[0] = '{32768, 0, 0, 1000, -1000, 1000, -1000};
        tbl[1] = '{16384, 16384, 0, 2000, 3, 1500, -499};
        tbl[2] = '{0, 0, -16384, 0, 0, 750, -250};
        tbl[3] = '{65536, 65536, 0, 30000, -30000, 32767, -32768};
        tbl[4] = '{32768, 0, 32768, 100, -100, -32667, 32668};
        tbl[5] = '{-32768, 0, 0, -32768, 5, 32767, -5};

        reset = 1'b1; div = 10'd32;
        a2v = 0; b1v = 0; b2v = 0; xv = '{0, 0};
        repeat (2) @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        model_reset();

        // hand-computed frames, state carried from one row to the next
        for (int i = 0; i < 6; i++) begin
            b1v = tbl[i].b1; b2v = tbl[i].b2; a2v = tbl[i].a2;
            xv[0] = tbl[i].x0; xv[1] = tbl[i].x1;
            wait_start();
            wait_valid();
            check($sformatf("tbl%0d_ch0", i), outch(0), tbl[i].e0);
            check($sformatf("tbl%0d_ch1", i), outch(1), tbl[i].e1);
        end

        // latency: T is the tick cycle where busy first shows
        div = 10'd32; do_reset();
        b1v = 32768; b2v = 0; a2v = 0; xv = '{-7, 4321};
        wait_start();
        model_latch();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("lat_busy_T+%0d", k), int'(busy), (k <= 8) ? 1 : 0);
            check($sformatf("lat_valid_T+%0d", k), int'(out_valid), (k == 9) ? 1 : 0);
            if (k == 9) begin
                check("lat_ch0", outch(0), exp_y[0]);
                check("lat_ch1", outch(1), exp_y[1]);
            end
        end

        // saturation
        b1v = 32767; b2v = 32767; a2v = 0; xv = '{32767, 0};
        for (int f = 0; f < 3; f++) do_frame($sformatf("satp%0d", f));
        check("satp_final", outch(0), 32767);
        xv[0] = -32768;
        for (int f = 0; f < 3; f++) do_frame($sformatf("satn%0d", f));
        check("satn_final", outch(0), -32768);

        // DC step with the default low-pass
        div = 10'd18; do_reset();
        b1v = B1_DEF; b2v = B2_DEF; a2v = A2_DEF; xv = '{16384, 0};
        prev = 0;
        for (int f = 0; f < 120; f++) begin
            do_frame($sformatf("dc%0d", f));
            check($sformatf("dc_mono%0d", f), (outch(0) >= prev) ? 1 : 0, 1);
            prev = outch(0);
        end

        // overrun: period shorter than a frame
        div = 10'd5; do_reset();
        check("ovr_clear", int'(overrun), 0);
        b1v = 32768; b2v = 0; a2v = 0; xv = '{111, -222};
        do_frame("ovr_f0");
        check("ovr_set", int'(overrun), 1);
        xv = '{-333, 444};
        do_frame("ovr_f1");
        xv = '{555, -666};
        do_frame("ovr_f2");
        check("ovr_hold", int'(overrun), 1);
        do_reset();
        check("ovr_reset", int'(overrun), 0);

        // reset during MAC1 of ch1 (T+6)
        div = 10'd32; do_reset();
        b1v = 32768; b2v = 16384; a2v = -8192; xv = '{9000, -9000};
        do_frame("pre_rst");
        wait_start();
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out", int'(out), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        reset = 1'b0;
        model_reset();
        do_frame("post_rst");

        // coefficient change during ch0 MAC2 (T+3)
        b1v = 20000; b2v = 10000; a2v = -8000; xv = '{1234, -2222};
        wait_start();
        model_latch();
        repeat (3) @(negedge clk);
        b1v = -15000;
        wait_valid();
        check("cchg_old_ch0", outch(0), exp_y[0]);
        check("cchg_old_ch1", outch(1), exp_y[1]);
        do_frame("cchg_new");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
